jtdd_objdma: RTL
================

Name: jtdd_objdma

Overview:
Bus-sharing initiator that pairs with the main-CPU bus grant logic. At each vertical-blank start it requests the main CPU bus and waits for the acknowledge. It then drives the shared 8 kB work RAM address (blcnten/obj_AB) to copy the 512-byte object table into a local object buffer, which the object scan engine reads during the active display.

Parameters:
LEN, 512, bytes copied per frame; obj_AB runs 0..LEN-1; 1 ≤ LEN ≤ 512.
TIMEOUT, 255, cen cycles to wait for bus_ack before aborting; 8-bit counter.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
cen  in  1  6 MHz clock enable; the same enable that clocks the shared RAM
LVBL  in  1  vertical blank, active low
bus_req  out  1  bus request to main CPU
bus_ack  in  1  bus granted (BA && BS)
blcnten  out  1  high: shared RAM address mux selects obj_AB, CPU writes blocked
obj_AB  out  9  shared RAM read address (RAM word {4'hf,obj_AB})
ram_dout  in  8  shared RAM read data; registered on cen, 1-cen latency
scan_addr  in  9  object engine read address
scan_dout  out  8  object buffer data; registered, 1 clk latency, not gated by cen
dma_busy  out  1  high in any state other than IDLE
dma_done  out  1  one-cen pulse after a complete copy
dma_err  out  1  sticky abort flag; cleared on the next successful copy

Behaviour:
- All state advances only on clk edges with cen=1, except the scan read port.
- Reset (async): state IDLE; bus_req, blcnten, dma_done, dma_err = 0; obj_AB = 0; timeout count = 0; bank = 0. Buffer contents are undefined.
- Trigger: LVBL falling edge, detected with last_LVBL sampled on cen. A trigger outside IDLE is ignored; it is neither queued nor restarts the copy.
- IDLE: on trigger -> REQ; bus_req <= 1; timeout count <= 0.
- REQ: bus_ack=1 -> COPY; blcnten <= 1; obj_AB <= 0.
  - Otherwise the count increments. When the count reaches TIMEOUT: bus_req <= 0, dma_err <= 1, -> IDLE.
- COPY: obj_AB is set to i on cen edge k+i, where k is the ack-sample edge.
  - ram_dout then holds mem[i] after edge k+i+1.
  - Buffer write buf[i] <= ram_dout occurs on edge k+i+2, tracked by a 1-stage valid/address pipeline.
  - obj_AB holds LEN-1 after it is issued; it does not wrap.
  - The final write (i=LEN-1) happens on edge k+LEN+1. On that same edge: blcnten <= 0, bus_req <= 0, -> DONE.
  - blcnten is therefore high for exactly LEN+1 cen periods.
- DONE: dma_done <= 1 for one cen period; dma_err <= 0; -> IDLE.
- bus_ack dropping during COPY: abort on that edge; blcnten <= 0, bus_req <= 0, dma_err <= 1, -> IDLE. Buffer writes already done are kept; the pending write is discarded.
- bus_ack=1 while in IDLE: ignored.
- Buffer: 512x8, written only by the copy path. The read port always returns the value at scan_addr from one clk earlier.
- Simultaneous buffer write and scan read of the same address: scan_dout returns the old data.

Optional Feature:
JTDD_OBJDMA_DBLBUF_EN: two 512-byte banks.
- The copy writes bank ~bank; the scan port reads bank.
- bank toggles on the DONE edge only. An aborted copy does not toggle it, so the scan side never sees a partial table.
- Without the macro: single bank. Scan reads see data updated mid-copy.

Test Plan:
- Reset mid-COPY (obj_AB=0x40): all outputs 0 immediately, before any clk edge; after release, the next LVBL fall starts a fresh copy from obj_AB=0.
- Shared RAM preloaded mem[0x1E00+i]=i^0x5A; LVBL falls; bus_ack asserted 3 cen later -> blcnten high for 513 cen, one dma_done pulse, scan_dout at address i equals i^0x5A for all 512 addresses.
- bus_ack held 0 -> bus_req drops exactly 255 cen after REQ entry, dma_err=1, blcnten never rises; the next successful copy clears dma_err.
- bus_ack dropped after 100 cen of COPY -> blcnten and bus_req fall on the same edge, dma_err=1, no dma_done pulse.
- Second LVBL fall injected during COPY -> ignored; exactly one dma_done pulse; copy length unchanged.
- With JTDD_OBJDMA_DBLBUF_EN, frame 1 data 0x11, frame 2 data 0x22 -> during frame 2 COPY scan_dout stays 0x11; after its dma_done scan_dout reads 0x22.

Source files
------------

// File: rtl/jtdd_objdma.sv
// -----------------------------------------------------------------------------
// jtdd_objdma
//
// Once per frame, on the falling edge of LVBL, this block asks the main CPU for
// its bus. When the bus is granted it walks the shared work RAM from word
// {4'hf, 0} to {4'hf, LEN-1} and copies each byte into a local object buffer.
// The object scan engine reads that buffer during active display through a
// separate port.
//
// Everything except the scan read port advances only on clk edges where cen=1.
//
// Optional build macro:
//   JTDD_OBJDMA_DBLBUF_EN : two buffer banks. The copy fills the hidden bank and
//                           the banks swap only after a complete copy, so the
//                           scan side never sees a partial table. Without the
//                           macro there is a single bank and the scan side sees
//                           the table change while it is being copied.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   cen          6 MHz clock enable shared with the work RAM
//   LVBL         vertical blank, active low
//   bus_req      bus request to the main CPU
//   bus_ack      bus granted (BA && BS)
//   blcnten      high while obj_AB drives the shared RAM address
//   obj_AB       shared RAM read address (RAM word {4'hf, obj_AB})
//   ram_dout     shared RAM read data, valid one cen after obj_AB
//   scan_addr    object engine read address
//   scan_dout    object buffer data, one clk after scan_addr
//   dma_busy     high outside IDLE
//   dma_done     one-cen pulse after a complete copy
//   dma_err      sticky abort flag, cleared by the next complete copy
// -----------------------------------------------------------------------------
module jtdd_objdma #(
    parameter int LEN     = 512,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       LVBL,
    output logic       bus_req,
    input  logic       bus_ack,
    output logic       blcnten,
    output logic [8:0] obj_AB,
    input  logic [7:0] ram_dout,
    input  logic [8:0] scan_addr,
    output logic [7:0] scan_dout,
    output logic       dma_busy,
    output logic       dma_done,
    output logic       dma_err
);

    localparam logic [8:0] LAST_ADDR = 9'(LEN - 1);
    localparam logic [9:0] LAST_CYC  = 10'(LEN - 1);
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COPY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_r, state_nx_s;
    logic       last_lvbl_r;
    logic       trigger_s;
    logic [7:0] tmo_cnt_r, tmo_cnt_nx_s;
    logic [9:0] cyc_r, cyc_nx_s;
    logic       pend_valid_r, pend_valid_nx_s;
    logic [8:0] pend_addr_r, pend_addr_nx_s;
    logic       bus_req_nx_s;
    logic       blcnten_nx_s;
    logic [8:0] obj_ab_nx_s;
    logic       dma_done_nx_s;
    logic       dma_err_nx_s;
    logic       buf_we_s;

    // last_lvbl_r is only refreshed on cen, so the edge is seen for exactly one cen
    assign trigger_s = last_lvbl_r & ~LVBL;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else if (cen) begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and next-value logic for the whole copy engine
    always_comb begin
        state_nx_s      = state_r;
        tmo_cnt_nx_s    = tmo_cnt_r;
        cyc_nx_s        = cyc_r;
        pend_valid_nx_s = pend_valid_r;
        pend_addr_nx_s  = pend_addr_r;
        bus_req_nx_s    = bus_req;
        blcnten_nx_s    = blcnten;
        obj_ab_nx_s     = obj_AB;
        dma_done_nx_s   = 1'b0;
        dma_err_nx_s    = dma_err;
        buf_we_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (trigger_s) begin
                    state_nx_s   = REQ;
                    bus_req_nx_s = 1'b1;
                    tmo_cnt_nx_s = 8'd0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_nx_s      = COPY;
                    blcnten_nx_s    = 1'b1;
                    obj_ab_nx_s     = 9'd0;
                    cyc_nx_s        = 10'd0;
                    pend_valid_nx_s = 1'b0;
                end else if ((tmo_cnt_r + 8'd1) == TMO_LIMIT) begin
                    state_nx_s   = IDLE;
                    tmo_cnt_nx_s = tmo_cnt_r + 8'd1;
                    bus_req_nx_s = 1'b0;
                    dma_err_nx_s = 1'b1;
                end else begin
                    tmo_cnt_nx_s = tmo_cnt_r + 8'd1;
                end
            end
            COPY: begin
                if (!bus_ack) begin
                    // Grant lost: drop the bus now; the write still in flight is lost
                    state_nx_s      = IDLE;
                    blcnten_nx_s    = 1'b0;
                    bus_req_nx_s    = 1'b0;
                    dma_err_nx_s    = 1'b1;
                    pend_valid_nx_s = 1'b0;
                end else begin
                    // ram_dout now holds the byte for the address issued two cen ago
                    buf_we_s = pend_valid_r;
                    if (obj_AB != LAST_ADDR) begin
                        obj_ab_nx_s = obj_AB + 9'd1;
                    end else begin
                        obj_ab_nx_s = obj_AB;
                    end
                    cyc_nx_s = cyc_r + 10'd1;
                    // Capture the address whose data the RAM is registering on this edge
                    if (cyc_r <= LAST_CYC) begin
                        pend_valid_nx_s = 1'b1;
                        pend_addr_nx_s  = obj_AB;
                    end else begin
                        pend_valid_nx_s = 1'b0;
                    end
                    if (pend_valid_r && (pend_addr_r == LAST_ADDR)) begin
                        state_nx_s      = DONE;
                        blcnten_nx_s    = 1'b0;
                        bus_req_nx_s    = 1'b0;
                        pend_valid_nx_s = 1'b0;
                    end else begin
                        state_nx_s = COPY;
                    end
                end
            end
            DONE: begin
                state_nx_s    = IDLE;
                dma_done_nx_s = 1'b1;
                dma_err_nx_s  = 1'b0;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Datapath and output registers of the copy engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lvbl_r  <= 1'b0;
            tmo_cnt_r    <= 8'd0;
            cyc_r        <= 10'd0;
            pend_valid_r <= 1'b0;
            pend_addr_r  <= 9'd0;
            bus_req      <= 1'b0;
            blcnten      <= 1'b0;
            obj_AB       <= 9'd0;
            dma_busy     <= 1'b0;
            dma_done     <= 1'b0;
            dma_err      <= 1'b0;
        end else if (cen) begin
            last_lvbl_r  <= LVBL;
            tmo_cnt_r    <= tmo_cnt_nx_s;
            cyc_r        <= cyc_nx_s;
            pend_valid_r <= pend_valid_nx_s;
            pend_addr_r  <= pend_addr_nx_s;
            bus_req      <= bus_req_nx_s;
            blcnten      <= blcnten_nx_s;
            obj_AB       <= obj_ab_nx_s;
            dma_busy     <= (state_nx_s != IDLE);
            dma_done     <= dma_done_nx_s;
            dma_err      <= dma_err_nx_s;
        end
    end

`ifdef JTDD_OBJDMA_DBLBUF_EN
    logic       bank_r;
    logic [7:0] buf_mem [0:1023];
    logic [9:0] wr_idx_s;
    logic [9:0] rd_idx_s;

    // The copy fills the bank the scan side is not looking at
    assign wr_idx_s = {~bank_r, pend_addr_r};
    assign rd_idx_s = {bank_r, scan_addr};

    // Bank swap only after a complete copy; aborted copies stay hidden
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_r <= 1'b0;
        end else if (cen && (state_r == DONE)) begin
            bank_r <= ~bank_r;
        end
    end
`else
    logic [7:0] buf_mem [0:511];
    logic [8:0] wr_idx_s;
    logic [8:0] rd_idx_s;

    assign wr_idx_s = pend_addr_r;
    assign rd_idx_s = scan_addr;
`endif

    // Object buffer write port, fed only by the copy pipeline
    always_ff @(posedge clk) begin
        if (cen && buf_we_s) begin
            buf_mem[wr_idx_s] <= ram_dout;
        end
    end

    // Scan read port: ungated by cen; a same-edge write returns the old byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_dout <= 8'd0;
        end else begin
            scan_dout <= buf_mem[rd_idx_s];
        end
    end

endmodule
